// File: rtl/lsu_req_tracker.sv
// Load/store request unit: issues split-transaction bus requests and tracks up to DEPTH in-order ops.
// Optional perf counters enabled by defining LSU_PERF_CNT_EN.
module lsu_req_tracker #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_store,
    input  logic [1:0]                  in_size,
    input  logic                        in_signed,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_wdata,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic                        flush,
    output logic                        bus_req,
    output logic                        bus_wr,
    output logic [1:0]                  bus_size,
    output logic [DATA_W/8-1:0]         bus_wstrb,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_wdata,
    input  logic                        bus_addr_ok,
    input  logic                        bus_data_ok,
    input  logic [DATA_W-1:0]           bus_rdata,
    output logic                        resp_valid,
    output logic                        resp_ale,
    output logic                        resp_store,
    output logic [TAG_W-1:0]            resp_tag,
    output logic [DATA_W-1:0]           resp_data,
    output logic [$clog2(DEPTH):0]      outstanding
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_req_cnt,
    output logic [31:0]                 perf_cancel_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic             q_store  [DEPTH];
    logic [1:0]       q_size   [DEPTH];
    logic             q_signed [DEPTH];
    logic [OFF_W-1:0] q_off    [DEPTH];
    logic [TAG_W-1:0] q_tag    [DEPTH];
    logic             q_ale    [DEPTH];
    logic             q_cancel [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic              ale, full, push, pop, head_cancel;
    logic [OFF_W-1:0]  in_off;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] shifted, load_ext;

    assign in_off  = in_addr[OFF_W-1:0];
    assign full    = (count_q == CNT_W'(DEPTH));

    always_comb begin
        ale = 1'b0;
        case (in_size)
            2'd1:    ale = in_addr[0];
            2'd2:    ale = |in_addr[1:0];
            2'd3:    ale = (DATA_W == 32) ? 1'b1 : |in_addr[2:0];
            default: ale = 1'b0;
        endcase
    end

    assign bus_req  = in_valid & ~ale & ~flush & ~full;
    assign in_ready = in_valid & ~flush & ~full & (ale | bus_addr_ok);
    assign bus_size = in_size;
    assign bus_addr = in_addr;
    assign push     = in_ready;

    always_comb begin
        strb_base = '0;
        bus_wdata = in_wdata;
        case (in_size)
            2'd0: begin
                strb_base = STRB_W'(1);
                bus_wdata = {(DATA_W/8){in_wdata[7:0]}};
            end
            2'd1: begin
                strb_base = STRB_W'(3);
                bus_wdata = {(DATA_W/16){in_wdata[15:0]}};
            end
            2'd2: begin
                strb_base = STRB_W'(15);
                bus_wdata = {(DATA_W/32){in_wdata[31:0]}};
            end
            default: begin
                strb_base = '1;
                bus_wdata = in_wdata;
            end
        endcase
    end

    assign bus_wstrb = in_store ? (strb_base << in_off) : '0;
    assign bus_wr    = |bus_wstrb;

    // An ALE head needs no bus response; flush suppresses a completion in the same cycle.
    assign pop         = (count_q != '0) & (q_ale[rd_ptr] | bus_data_ok);
    assign head_cancel = q_cancel[rd_ptr] | flush;
    assign resp_valid  = pop & ~head_cancel;

    assign shifted = bus_rdata >> {q_off[rd_ptr], 3'b000};

    always_comb begin
        load_ext = shifted;
        case (q_size[rd_ptr])
            2'd0: load_ext = q_signed[rd_ptr] ? DATA_W'($signed(shifted[7:0]))
                                              : DATA_W'(shifted[7:0]);
            2'd1: load_ext = q_signed[rd_ptr] ? DATA_W'($signed(shifted[15:0]))
                                              : DATA_W'(shifted[15:0]);
            2'd2: load_ext = q_signed[rd_ptr] ? DATA_W'($signed(shifted[31:0]))
                                              : DATA_W'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
    end

    assign resp_ale    = resp_valid & q_ale[rd_ptr];
    assign resp_store  = resp_valid & q_store[rd_ptr];
    assign resp_tag    = resp_valid ? q_tag[rd_ptr] : '0;
    assign resp_data   = (resp_valid & ~q_store[rd_ptr] & ~q_ale[rd_ptr]) ? load_ext : '0;
    assign outstanding = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_store[i]  <= 1'b0;
                q_size[i]   <= '0;
                q_signed[i] <= 1'b0;
                q_off[i]    <= '0;
                q_tag[i]    <= '0;
                q_ale[i]    <= 1'b0;
                q_cancel[i] <= 1'b0;
            end
        end else begin
            // Stale slots may be marked too; a push always rewrites cancel.
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) q_cancel[i] <= 1'b1;
            end
            if (push) begin
                q_store[wr_ptr]  <= in_store;
                q_size[wr_ptr]   <= in_size;
                q_signed[wr_ptr] <= in_signed;
                q_off[wr_ptr]    <= in_off;
                q_tag[wr_ptr]    <= in_tag;
                q_ale[wr_ptr]    <= ale;
                q_cancel[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        bus_data_ok |-> ((count_q != '0) && !q_ale[rd_ptr]));

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_req_cnt    <= '0;
            perf_cancel_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (bus_req & bus_addr_ok)       perf_req_cnt    <= perf_req_cnt + 32'd1;
            if (pop & head_cancel)           perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
            if (in_valid & ~in_ready & ~flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/lsu_req_tracker.md
Name: lsu_req_tracker

Overview:
- Parametrised load/store request unit for the execute/memory boundary.
- Issues byte/half/word(/dword) requests on an addr_ok/data_ok split-transaction data bus and tracks up to DEPTH outstanding requests in order.
- Checks alignment (ALE) and returns aligned, sign/zero-extended load data with the destination tag to the memory stage.
- Supports flush, so in-flight responses of cancelled requests are drained silently.

Parameters:
- DATA_W, 32: bus/register width; 32 or 64 only.
- ADDR_W, 32: address width.
- DEPTH, 2: max outstanding requests; power of two, 2..8.
- TAG_W, 5: destination tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  op offered by execute stage
- in_ready  out  1  op accepted this cycle
- in_store  in  1  1=store, 0=load
- in_size  in  2  0=B, 1=H, 2=W, 3=D (D legal only when DATA_W=64)
- in_signed  in  1  sign-extend load
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store data, LSB-aligned
- in_tag  in  TAG_W  destination tag
- flush  in  1  cancel all accepted, unreturned ops
- bus_req  out  1  request valid
- bus_wr  out  1  write
- bus_size  out  2  =in_size
- bus_wstrb  out  DATA_W/8  byte strobes
- bus_addr  out  ADDR_W  =in_addr
- bus_wdata  out  DATA_W  replicated store data
- bus_addr_ok  in  1  request accepted
- bus_data_ok  in  1  response valid
- bus_rdata  in  DATA_W  raw read data
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_ale  out  1  completed op was misaligned
- resp_store  out  1  completed op was store
- resp_tag  out  TAG_W
- resp_data  out  DATA_W  extended load data; 0 for stores/ALE
- outstanding  out  $clog2(DEPTH)+1  live tracker occupancy

Behaviour:
- Misalignment: ale = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (size==3 & addr[2:0]!=0). Size 3 with DATA_W=32 is treated as ALE.
- Lane offset: off = addr[$clog2(DATA_W/8)-1:0].
- bus_req = in_valid & ~ale & ~flush & ~full.
- bus_wstrb = store ? (((1<<(1<<size))-1) << off) : 0; bus_wr = |bus_wstrb.
- bus_wdata: B replicates [7:0], H replicates [15:0], W replicates [31:0], D passes through.
- in_ready = in_valid & ~flush & ~full & (ale | bus_addr_ok). An ALE op is accepted without a bus request.
- Tracker: circular FIFO of DEPTH entries {store, size, signed, off, tag, ale, cancel}, written on in_ready. full = (count==DEPTH).
- Head completion:
  - Non-ALE head completes on bus_data_ok.
  - ALE head completes the cycle after it is at head, with no data_ok needed.
  - Completion pops the head.
  - resp_valid = pop & ~cancel.
- bus_data_ok arriving while the FIFO is empty or the head is ALE is a protocol error; assertion only, data ignored.
- Simultaneous push and pop: count unchanged. A push on a full FIFO is impossible because in_ready=0 when full, even if pop occurs in the same cycle; no bypass.
- Load data: shift bus_rdata right by off*8, then zero/sign-extend from 8/16/32 bits to DATA_W.
- Flush:
  - Sets cancel on all live entries that same cycle; in_ready=0 and bus_req=0 during flush.
  - Cancelled ALE entries pop immediately next cycle.
  - Cancelled bus entries pop silently on their data_ok.
  - New ops are accepted from the next cycle and complete after the drained ones.
- Pointers wrap modulo DEPTH.
- Latency: load response ≥1 cycle after addr_ok (the cycle of data_ok); ALE response 1 cycle after accept at head.
- Reset: count=0, pointers=0, all cancel=0, resp_valid=0, resp_* =0. Outputs are combinational from registered state plus inputs; no outputs are X after reset.
- Reset mid-transaction: tracker is cleared; later stray data_ok is ignored.

Optional Feature:
- Macro LSU_PERF_CNT_EN adds outputs perf_req_cnt[31:0] (bus requests accepted), perf_cancel_cnt[31:0] (cancelled completions) and perf_stall_cnt[31:0] (cycles with in_valid & ~in_ready & ~flush).
- Counters wrap at 2^32 and clear on reset.
- Without the macro these ports and registers do not exist.

Test Plan:
- DATA_W=32, ld.b signed, addr 0x1003, rdata 0x80aabbcc, addr_ok next cycle, data_ok 2 cycles later -> resp_valid once, resp_data 0xffffff80, tag preserved.
- st.h addr 0x2002, wdata 0x1234 -> bus_wstrb 4'b1100, bus_wdata 0x12341234, bus_wr=1; data_ok -> resp_store=1, resp_data 0.
- ld.w addr 0x3001 -> no bus_req, in_ready same cycle, resp_ale=1 next cycle; outstanding returns to 0.
- DEPTH=2: three back-to-back loads with addr_ok=1, data_ok held low -> third load sees in_ready=0 and outstanding=2; first data_ok re-enables accept next cycle; responses return in order.
- Two loads outstanding, flush pulse, then new load tag 7 -> first two data_ok produce no resp_valid; third data_ok gives resp_valid with tag 7.
- DATA_W=64, ld.d addr 0x8 -> bus_size 3, full 64-bit data returned; ld.wu addr 0xC with rdata 0x89abcdef_01234567 -> resp_data 0x00000000_89abcdef.
